// File: rtl/ram_march_bist.sv
// March C- BIST master for a single-port RAM with combinational read data.
// Drives one RAM operation per cycle and records pass/fail plus first-failure details.
module ram_march_bist #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FAIL_CNT_W = 8,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [AW-1:0]         fail_addr,
  output logic [WIDTH-1:0]      fail_data,
  output logic [WIDTH-1:0]      fail_exp,
  output logic [FAIL_CNT_W-1:0] fail_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [AW-1:0] AddrMax = AW'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    phase_q, phase_d;
  logic                    last_op;

  logic                    pass_q, pass_d;
  logic [AW-1:0]           faddr_q, faddr_d;
  logic [WIDTH-1:0]        fdata_q, fdata_d;
  logic [WIDTH-1:0]        fexp_q, fexp_d;
  logic [FAIL_CNT_W-1:0]   fcnt_q, fcnt_d;

  logic                    is_read;
  logic                    mismatch;
  logic [WIDTH-1:0]        exp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      elem_q  <= 3'd0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      pass_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      fexp_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      pass_q  <= pass_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      fexp_q  <= fexp_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Elements 0..2 walk upward, 3..5 downward; phase 0 = read, 1 = write in M1..M4.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    last_op = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          elem_d  = 3'd0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      StRun: begin
        if (elem_q == 3'd0) begin
          if (addr_q == AddrMax) begin
            elem_d = 3'd1;
            addr_d = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else if (elem_q == 3'd5) begin
          if (addr_q == '0) begin
            state_d = StDone;
            last_op = 1'b1;
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (elem_q <= 3'd2) begin
            if (addr_q == AddrMax) begin
              elem_d = elem_q + 3'd1;
              addr_d = (elem_q == 3'd2) ? AddrMax : '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            if (addr_q == '0) begin
              elem_d = elem_q + 3'd1;
              addr_d = AddrMax;
            end else begin
              addr_d = addr_q - 1'b1;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    is_read   = busy && ((elem_q == 3'd5) || ((elem_q != 3'd0) && !phase_q));
    exp_data  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
    mem_we    = busy && !is_read;
    mem_addr  = busy ? addr_q : '0;
    mem_wdata = '0;
    if (mem_we && ((elem_q == 3'd1) || (elem_q == 3'd3))) begin
      mem_wdata = '1;
    end
    mismatch  = is_read && (mem_rdata != exp_data);
  end

  // The counter never wraps, so a zero count means no miscompare yet this run.
  always_comb begin
    pass_d  = pass_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    fexp_d  = fexp_q;
    fcnt_d  = fcnt_q;
    if ((state_q == StIdle) && start) begin
      pass_d  = 1'b0;
      faddr_d = '0;
      fdata_d = '0;
      fexp_d  = '0;
      fcnt_d  = '0;
    end else begin
      if (mismatch) begin
        if (fcnt_q == '0) begin
          faddr_d = addr_q;
          fdata_d = mem_rdata;
          fexp_d  = exp_data;
        end
        if (fcnt_q != '1) begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      if (last_op) begin
        pass_d = (fcnt_d == '0);
      end
    end
  end

  assign pass       = pass_q;
  assign fail_addr  = faddr_q;
  assign fail_data  = fdata_q;
  assign fail_exp   = fexp_q;
  assign fail_count = fcnt_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: RAM model with fault injection, March C- op scoreboard,
// table of result vectors, plus reset-abort and saturating-counter sequences.
module tb_ram_march_bist;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, start, start_s;
  logic          mem_we, busy, done, pass;
  logic [AW-1:0] mem_addr, fail_addr;
  logic [W-1:0]  mem_wdata, mem_rdata, fail_data, fail_exp;
  logic [7:0]    fail_count;

  logic          s_we, s_busy, s_done, s_pass;
  logic [AW-1:0] s_addr, s_faddr;
  logic [W-1:0]  s_wdata, s_fdata, s_fexp;
  logic [1:0]    s_cnt;
  logic [W-1:0]  s_rdata;

  always #5 clk = ~clk;

  ram_march_bist #(.WIDTH(W), .DEPTH(D), .FAIL_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_exp(fail_exp),
    .fail_count(fail_count)
  );

  assign s_rdata = 8'h55;

  ram_march_bist #(.WIDTH(W), .DEPTH(D), .FAIL_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .mem_rdata(s_rdata), .busy(s_busy), .done(s_done), .pass(s_pass),
    .fail_addr(s_faddr), .fail_data(s_fdata), .fail_exp(s_fexp), .fail_count(s_cnt)
  );

  // RAM model: synchronous write, combinational read, with injected faults by mode.
  logic [W-1:0] ram [D];
  int mode = 0;
  int cyc  = 0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    cyc <= (busy === 1'b1) ? cyc + 1 : 0;
  end

  always_comb begin
    mem_rdata = ram[mem_addr];
    if (mode == 1 && mem_addr == 3'd5) mem_rdata[3] = 1'b1;
    if (mode == 2 && cyc == 66 && mem_addr == 3'd2 && !mem_we) mem_rdata = 8'hFE;
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
  } op_t;

  typedef struct {
    int mode;
    bit exp_pass;
    int exp_cnt;
    int faddr;
    int fdata;
    int fexp;
  } vec_t;

  op_t  exp_q[$];
  vec_t vecs[3];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input bit we, input int a, input logic [W-1:0] wd);
    op_t o;
    o.we = we;
    o.addr = AW'(a);
    o.wdata = wd;
    return o;
  endfunction

  // Expected op stream of one full March C- run.
  task automatic push_run();
    for (int a = 0; a < D; a++) exp_q.push_back(mk(1, a, 8'h00));
    for (int a = 0; a < D; a++) begin
      exp_q.push_back(mk(0, a, 8'h00));
      exp_q.push_back(mk(1, a, 8'hFF));
    end
    for (int a = 0; a < D; a++) begin
      exp_q.push_back(mk(0, a, 8'h00));
      exp_q.push_back(mk(1, a, 8'h00));
    end
    for (int a = D - 1; a >= 0; a--) begin
      exp_q.push_back(mk(0, a, 8'h00));
      exp_q.push_back(mk(1, a, 8'hFF));
    end
    for (int a = D - 1; a >= 0; a--) begin
      exp_q.push_back(mk(0, a, 8'h00));
      exp_q.push_back(mk(1, a, 8'h00));
    end
    for (int a = D - 1; a >= 0; a--) exp_q.push_back(mk(0, a, 8'h00));
  endtask

  task automatic wait_launch();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < 10);
    chk("launch_latency", n, 1);
    chk("clr_pass", pass, 0);
    chk("clr_count", fail_count, 0);
    chk("clr_faddr", fail_addr, 0);
    chk("clr_fdata", fail_data, 0);
    chk("clr_fexp", fail_exp, 0);
  endtask

  task automatic do_run(input vec_t v, input bit hold, input bit jitter);
    int  cycles;
    op_t op;
    mode  = v.mode;
    start = 1'b1;
    push_run();
    wait_launch();
    if (!hold) start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      op = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("op", {mem_we, mem_addr, mem_wdata}, op);
      cycles++;
      if (jitter) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
    chk("busy_len", cycles, 80);
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_we", mem_we, 0);
    chk("done_addr", mem_addr, 0);
    chk("done_wdata", mem_wdata, 0);
    chk("pass", pass, v.exp_pass);
    chk("fail_count", fail_count, v.exp_cnt);
    chk("fail_addr", fail_addr, v.faddr);
    chk("fail_data", fail_data, v.fdata);
    chk("fail_exp", fail_exp, v.fexp);
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{mode: 0, exp_pass: 1'b1, exp_cnt: 0, faddr: 0, fdata: 'h00, fexp: 'h00};
    vecs[1] = '{mode: 1, exp_pass: 1'b0, exp_cnt: 3, faddr: 5, fdata: 'h08, fexp: 'h00};
    vecs[2] = '{mode: 2, exp_pass: 1'b0, exp_cnt: 1, faddr: 2, fdata: 'hFE, fexp: 'hFF};

    rst = 1'b1;
    start = 1'b0;
    start_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", fail_count, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) do_run(vecs[i], 1'b0, i == 1);

    // start held high: back-to-back runs, results cleared at relaunch
    do_run(vecs[1], 1'b1, 1'b0);
    do_run(vecs[0], 1'b0, 1'b0);

    // reset in the middle of a failing run
    mode  = 1;
    start = 1'b1;
    wait_launch();
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_rst_count", fail_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_count", fail_count, 0);
    chk("abort_faddr", fail_addr, 0);
    chk("abort_fdata", fail_data, 0);
    chk("abort_pass", pass, 0);
    do_run(vecs[0], 1'b0, 1'b0);

    // narrow counter, stuck read data
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (s_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sat_run_len", n, 80);
    chk("sat_count", s_cnt, 3);
    chk("sat_pass", s_pass, 0);
    chk("sat_faddr", s_faddr, 0);
    chk("sat_fdata", s_fdata, 8'h55);
    chk("sat_fexp", s_fexp, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
